c2f_chunk_ring: RTL
===================

C2F_CHUNK_RING -- requirements
Module: c2f_chunk_ring

Interface
REQ-001 SHALL have parameter NUM_CHUNKS, default 4: ring depth in chunks, power of two, at least 2.
REQ-002 SHALL have parameter CHUNK_QWS, default 64: chunk length in 64-bit QWs, power of two, at least 2.
REQ-003 SHALL have parameter WB_EVERY, default 1: number of chunks consumed between read-pointer write-backs; 1 means every chunk.
REQ-004 SHALL have port pcieClk_in, input, 1 bit: the single clock.
REQ-005 SHALL have port pcieRst_in, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port enable_in, input, 1 bit: DMA_ENABLE register bit; 0 holds the ring cleared.
REQ-007 SHALL have port wrValid_in, input, 1 bit: host QW write strobe from the C2F BAR.
REQ-008 SHALL have port wrAddr_in, input, log2(NUM_CHUNKS*CHUNK_QWS) bits: QW index in the ring.
REQ-009 SHALL have port wrData_in, input, 64 bits: QW payload.
REQ-010 SHALL have ports wrPtrValid_in (input, 1) and wrPtr_in (input, log2(NUM_CHUNKS)): host commit of a new write pointer.
REQ-011 SHALL have ports data_out (output, 64), valid_out (output, 1) and ready_in (input, 1): consumer stream.
REQ-012 SHALL have ports mtrReq_out (output, 1), mtrPtr_out (output, log2(NUM_CHUNKS)) and mtrAck_in (input, 1): read-pointer DMA request to the TLP transmitter.
REQ-013 SHALL have ports empty_out (output, 1) and overflow_out (output, 1, sticky).

Function
REQ-014 SHALL store each write with wrValid_in=1 at wrAddr_in, unconditionally (no full check on the data path).
REQ-015 SHALL latch wrPtr_in into wrPtr on a cycle where wrPtrValid_in=1 and enable_in=1.
REQ-016 SHALL set overflow_out when a committed wrPtr gives (wrPtr-rdPtr) mod NUM_CHUNKS smaller than the previous occupancy (host lapped rdPtr); SHALL still accept that commit.
REQ-017 SHALL drive empty_out=1 exactly when rdPtr==wrPtr.
REQ-018 SHALL read the ring at {rdPtr,qwIdx}, with RAM read latency 1 and a 2-entry output skid buffer; valid_out SHALL follow AXI-style rules (data held stable while valid_out=1 and ready_in=0).
REQ-019 SHALL give a latency of 3 cycles or fewer from a commit that makes the ring non-empty to valid_out=1; with ready_in held at 1, SHALL deliver 1 QW per cycle, including across chunk boundaries.
REQ-020 SHALL increment qwIdx on each accepted QW; on the last QW of a chunk, qwIdx SHALL wrap to 0 and rdPtr SHALL increment modulo NUM_CHUNKS.
REQ-021 SHALL not prefetch a chunk whose index equals wrPtr.
REQ-022 SHALL implement the write-back FSM with states IDLE and REQ:
- IDLE to REQ when the count of consumed chunks since the last write-back reaches WB_EVERY; mtrPtr_out takes the current rdPtr.
- REQ holds mtrReq_out=1 and a stable mtrPtr_out until mtrAck_in=1, then returns to IDLE.
REQ-023 SHALL coalesce chunks completed while in REQ: they count toward the next write-back, whose pointer SHALL be the newest rdPtr.
REQ-024 SHALL treat chunk completion and mtrAck_in in the same cycle as: ack consumed, and the new chunk counted.
REQ-025 SHALL, while enable_in=0, clear wrPtr, rdPtr, qwIdx, the skid buffer, the FSM and overflow_out, and drive valid_out=0 and mtrReq_out=0; RAM contents are retained.
REQ-026 SHALL, on enable_in falling during REQ, abandon the request the next cycle without waiting for mtrAck_in.

Reset
REQ-027 SHALL, on pcieRst_in=1, give the same register state as enable_in=0: data_out=0, valid_out=0, mtrReq_out=0, mtrPtr_out=0, empty_out=1, overflow_out=0.
REQ-028 SHALL make reset take priority over all inputs in the same cycle; a mid-chunk reset discards the partial chunk.

Structure
REQ-029 SHALL take the C2FChunkIndex typedef, the QW typedef and the NUM_CHUNKS/CHUNK_QWS defaults from tlp_xcvr_pkg; no new package.
REQ-030 SHALL instantiate the ring storage as the single sub-module ram_sdp (simple dual-port, 64-bit, registered read).

Verification (NUM_CHUNKS=4, CHUNK_QWS=8)
REQ-031 SHALL cover: write QWs 0..7, commit wrPtr=1, ready_in=1 -> QWs 0..7 out on 8 consecutive cycles, then empty_out=1, mtrReq_out=1 with mtrPtr_out=1.
REQ-032 SHALL cover: fill 3 chunks, commit wrPtr=3, ready_in toggling 1/0 -> all 24 QWs in order, no duplicates or drops, final rdPtr=3.
REQ-033 SHALL cover: mtrAck_in held 0 while 3 chunks are consumed -> one request, mtrPtr_out stable at 1; ack -> next request carries mtrPtr_out=3.
REQ-034 SHALL cover: WB_EVERY=2, consume 4 chunks with immediate ack -> exactly two requests, pointers 2 and 0 (wrap).
REQ-035 SHALL cover: with rdPtr=0 and occupancy 3, commit wrPtr=1 -> overflow_out=1 and stays 1 until enable_in=0.
REQ-036 SHALL cover: enable_in=0 at QW 4 of a chunk -> next cycle valid_out=0, empty_out=1, mtrReq_out=0; re-enable and commit wrPtr=1 -> stream restarts at ring QW 0.

Source files
------------

// File: rtl/tlp_xcvr_pkg.sv
// Shared types and ring geometry defaults for the TLP transceiver blocks.
package tlp_xcvr_pkg;
  localparam int C2F_NUM_CHUNKS = 4;
  localparam int C2F_CHUNK_QWS  = 64;

  typedef logic [63:0]                         QW;
  typedef logic [$clog2(C2F_NUM_CHUNKS)-1:0]   C2FChunkIndex;
endpackage

// File: rtl/ram_sdp.sv
// Simple dual-port RAM: one write port, one registered read port, no reset on storage.
module ram_sdp #(
  parameter int AW = 8,
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [1<<AW];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/c2f_chunk_ring.sv
// Host-to-FPGA chunk ring: host fills QWs and commits a write pointer, the consumer
// drains chunks in order, and consumed-chunk progress is written back via a DMA request.
//
//  state | meaning
//  IDLE  | counting consumed chunks toward the next write-back
//  REQ   | write-back request outstanding, mtrPtr_out frozen until ack
module c2f_chunk_ring
  import tlp_xcvr_pkg::*;
#(
  parameter int NUM_CHUNKS = C2F_NUM_CHUNKS,
  parameter int CHUNK_QWS  = C2F_CHUNK_QWS,
  parameter int WB_EVERY   = 1
) (
  input  logic                                      pcieClk_in,
  input  logic                                      pcieRst_in,
  input  logic                                      enable_in,
  input  logic                                      wrValid_in,
  input  logic [$clog2(NUM_CHUNKS*CHUNK_QWS)-1:0]   wrAddr_in,
  input  QW                                         wrData_in,
  input  logic                                      wrPtrValid_in,
  input  logic [$clog2(NUM_CHUNKS)-1:0]             wrPtr_in,
  output QW                                         data_out,
  output logic                                      valid_out,
  input  logic                                      ready_in,
  output logic                                      mtrReq_out,
  output logic [$clog2(NUM_CHUNKS)-1:0]             mtrPtr_out,
  input  logic                                      mtrAck_in,
  output logic                                      empty_out,
  output logic                                      overflow_out
);

  localparam int PW  = $clog2(NUM_CHUNKS);
  localparam int QIW = $clog2(CHUNK_QWS);
  localparam int AW  = PW + QIW;
  localparam int CW  = $clog2(WB_EVERY + 1);

  typedef enum logic {IDLE, REQ} wb_state_e;

  logic [PW-1:0]  wr_ptr, rd_ptr, rd_ptr_nxt, fetch_ptr;
  logic [QIW-1:0] qw_idx, fetch_idx;
  logic [PW-1:0]  occ_old, occ_new;
  logic           clear;
  logic           rd_inflight, rd_issue, pop, chunk_done;
  logic [2:0]     credit_used;
  QW              ram_q, skid0, skid1;
  logic [1:0]     skid_cnt;
  logic           overflow;

  wb_state_e      state, state_nxt;
  logic [CW-1:0]  wb_cnt, wb_cnt_nxt, cnt_inc;
  logic [PW-1:0]  mtr_ptr, mtr_ptr_nxt;

  assign clear = pcieRst_in || !enable_in;

  ram_sdp #(.AW(AW), .DW(64)) u_ram (
    .clk     (pcieClk_in),
    .wr_en   (wrValid_in),
    .wr_addr (wrAddr_in),
    .wr_data (wrData_in),
    .rd_en   (rd_issue),
    .rd_addr ({fetch_ptr, fetch_idx}),
    .rd_data (ram_q)
  );

  // Skid entries plus the read in flight, minus the entry leaving this cycle, must stay
  // below two so a returning RAM word always has a slot.
  always_comb begin
    valid_out   = enable_in && (skid_cnt != 2'd0);
    pop         = valid_out && ready_in;
    credit_used = {1'b0, skid_cnt} + {2'b00, rd_inflight} - {2'b00, pop};
    rd_issue    = enable_in && (fetch_ptr != wr_ptr) && (credit_used < 3'd2);
    chunk_done  = pop && (qw_idx == QIW'(CHUNK_QWS - 1));
    rd_ptr_nxt  = chunk_done ? rd_ptr + 1'b1 : rd_ptr;
    occ_old     = wr_ptr - rd_ptr;
    occ_new     = wrPtr_in - rd_ptr;
  end

  always_ff @(posedge pcieClk_in) begin
    if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      qw_idx    <= '0;
      fetch_ptr <= '0;
      fetch_idx <= '0;
      overflow  <= 1'b0;
    end else begin
      if (wrPtrValid_in) begin
        wr_ptr <= wrPtr_in;
        if (occ_new < occ_old) overflow <= 1'b1;
      end
      if (rd_issue) begin
        fetch_idx <= fetch_idx + 1'b1;
        if (fetch_idx == QIW'(CHUNK_QWS - 1)) fetch_ptr <= fetch_ptr + 1'b1;
      end
      if (pop) begin
        qw_idx <= qw_idx + 1'b1;
        rd_ptr <= rd_ptr_nxt;
      end
    end
  end

  always_ff @(posedge pcieClk_in) begin
    if (clear) begin
      rd_inflight <= 1'b0;
      skid_cnt    <= 2'd0;
      skid0       <= '0;
      skid1       <= '0;
    end else begin
      rd_inflight <= rd_issue;
      case ({rd_inflight, pop})
        2'b10: begin
          if (skid_cnt == 2'd0) skid0 <= ram_q;
          else                  skid1 <= ram_q;
          skid_cnt <= skid_cnt + 2'd1;
        end
        2'b01: begin
          skid0    <= skid1;
          skid_cnt <= skid_cnt - 2'd1;
        end
        2'b11: begin
          if (skid_cnt == 2'd1) begin
            skid0 <= ram_q;
          end else begin
            skid0 <= skid1;
            skid1 <= ram_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign data_out     = skid0;
  assign empty_out    = (rd_ptr == wr_ptr);
  assign overflow_out = overflow;

  // Chunks finishing while a request is outstanding keep counting; the counter
  // saturates at WB_EVERY since only the threshold matters.
  always_comb begin
    state_nxt   = state;
    wb_cnt_nxt  = wb_cnt;
    mtr_ptr_nxt = mtr_ptr;
    cnt_inc     = (chunk_done && (wb_cnt != CW'(WB_EVERY))) ? wb_cnt + 1'b1 : wb_cnt;
    case (state)
      IDLE: begin
        if (cnt_inc == CW'(WB_EVERY)) begin
          state_nxt   = REQ;
          wb_cnt_nxt  = '0;
          mtr_ptr_nxt = rd_ptr_nxt;
        end else begin
          wb_cnt_nxt = cnt_inc;
        end
      end
      REQ: begin
        wb_cnt_nxt = cnt_inc;
        if (mtrAck_in) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pcieClk_in) begin
    if (clear) begin
      state   <= IDLE;
      wb_cnt  <= '0;
      mtr_ptr <= '0;
    end else begin
      state   <= state_nxt;
      wb_cnt  <= wb_cnt_nxt;
      mtr_ptr <= mtr_ptr_nxt;
    end
  end

  assign mtrReq_out = enable_in && (state == REQ);
  assign mtrPtr_out = mtr_ptr;

endmodule
